// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: default widths, opcodes,
// instruction-word field offsets and the sequencer state encoding.
package cpu_pkg;

  localparam int CPU_AW = 4;
  localparam int CPU_DW = 8;
  localparam int OPC_W  = 4;

  // Instruction word layout: {opcode, address, operand}, operand in the LSBs.
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = CPU_DW;
  localparam int OPC_LSB  = CPU_DW + CPU_AW;

  localparam logic [OPC_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OPC_W-1:0] OP_INPUT  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_OUTPUT = 4'b0110;
  localparam logic [OPC_W-1:0] OP_HLT    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_program_sequencer_prog_ram.sv
// Program RAM: synchronous write, registered read. The read register doubles
// as the sequencer's instruction register. A read that hits the word being
// written in the same cycle returns the new data (write-first).
module prog_ram #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Word write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read with write-first bypass.
  always_ff @(posedge clk) begin
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/cpu_program_sequencer.sv
// Instruction-issuing front end: holds a small program, steps through it one
// instruction every three cycles (FETCH, ISSUE, CAPTURE), drives the CPU
// inputs during ISSUE only and captures the CPU result one cycle later.
//
// Handshake: there is no backpressure. result_valid is a single-cycle pulse
// that is high exactly in the cycle where result first shows a newly captured
// value; a consumer must take result in that cycle or read it later while it
// holds.
module cpu_program_sequencer
  import cpu_pkg::*;
#(
  parameter int         AW      = CPU_AW,
  parameter int         DW      = CPU_DW,
  parameter logic [3:0] IDLE_OP = OP_OUTPUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [4+AW+DW-1:0] prog_wdata,
  input  logic              start,
  input  logic              abort,
  input  logic [DW-1:0]     cpu_result,
  output logic [3:0]        cpu_opcode,
  output logic [AW-1:0]     cpu_address,
  output logic [DW-1:0]     cpu_data,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc,
  output logic [DW-1:0]     result,
  output logic              result_valid,
  output logic [AW:0]       instr_count,
  output state_t            state_dbg
);

  localparam int            IW      = 4 + AW + DW;
  localparam logic [AW-1:0] LAST_PC = {AW{1'b1}};
  localparam logic [AW:0]   MAX_CNT = {1'b1, {AW{1'b0}}};

  state_t        state, state_nxt;
  logic [IW-1:0] ir;
  logic          ram_we;
  logic          ram_re;
  logic          ir_is_hlt;

  assign ir_is_hlt = (ir[IW-1 -: 4] == OP_HLT);
  assign state_dbg = state;

  prog_ram #(.AW(AW), .W(IW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (ram_re),
    .raddr (pc),
    .rdata (ir)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state, CPU drive and status; abort wins over everything but reset.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    cpu_opcode  = IDLE_OP;
    cpu_address = '0;
    cpu_data    = '0;
    ram_re      = 1'b0;
    ram_we      = rst && prog_we && ((state == ST_IDLE) || (state == ST_DONE));
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        busy      = 1'b1;
        ram_re    = 1'b1;
        state_nxt = abort ? ST_IDLE : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy                                = 1'b1;
        {cpu_opcode, cpu_address, cpu_data} = ir;
        if (abort)          state_nxt = ST_IDLE;
        else if (ir_is_hlt) state_nxt = ST_DONE;
        else                state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (abort)                state_nxt = ST_IDLE;
        else if (pc == LAST_PC)   state_nxt = ST_DONE;
        else                      state_nxt = ST_FETCH;
      end
      ST_DONE: begin
        done = 1'b1;
        if (abort)      state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Program counter, issue counter and result capture; all hold on abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= '0;
      instr_count  <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        ST_ISSUE: begin
          if (!abort && (instr_count != MAX_CNT)) instr_count <= instr_count + 1'b1;
        end
        ST_CAPTURE: begin
          if (!abort) begin
            result       <= cpu_result;
            result_valid <= 1'b1;
            if (pc != LAST_PC) pc <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Bench for cpu_program_sequencer: a small CPU stand-in, an instruction-level
// reference model with a latency schedule, a per-cycle compare process,
// directed literal checks and randomized stimulus.
module tb_cpu_program_sequencer;
  import cpu_pkg::*;

  localparam int         DEPTH   = 16;
  localparam logic [3:0] IDLE_OP = 4'b0110;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_wdata = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cpu_result = 8'h00;
  logic [3:0]  cpu_opcode;
  logic [3:0]  cpu_address;
  logic [7:0]  cpu_data;
  logic        busy, done, result_valid;
  logic [3:0]  pc;
  logic [7:0]  result;
  logic [4:0]  instr_count;
  state_t      state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  cpu_program_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort),
    .cpu_result(cpu_result), .cpu_opcode(cpu_opcode), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .busy(busy), .done(done), .pc(pc), .result(result),
    .result_valid(result_valid), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  // ---------------- CPU semantics (stand-in core) ----------------
  function automatic logic [7:0] op_res(input logic [3:0] op, input logic [7:0] mval,
                                        input logic [7:0] d, input logic [7:0] old);
    case (op)
      4'h0:    return mval + d;
      4'h5:    return d;
      4'h6:    return mval;
      4'hF:    return old;
      default: return mval ^ d;
    endcase
  endfunction

  function automatic logic [7:0] op_mem(input logic [3:0] op, input logic [7:0] mval,
                                        input logic [7:0] d);
    case (op)
      4'h0:    return mval + d;
      4'h5:    return d;
      default: return mval;
    endcase
  endfunction

  logic [7:0] cpu_mem [DEPTH] = '{default: 8'h00};
  always @(posedge clk) begin
    cpu_result <= op_res(cpu_opcode, cpu_mem[cpu_address], cpu_data, cpu_result);
    cpu_mem[cpu_address] <= op_mem(cpu_opcode, cpu_mem[cpu_address], cpu_data);
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_prog   [DEPTH];
  logic [15:0] run_prog [DEPTH];
  logic [7:0]  ref_mem  [DEPTH] = '{default: 8'h00};
  logic [7:0]  m_res    [DEPTH];
  logic [7:0]  exp_q[$];
  bit          m_active = 1'b0;
  bit          m_hlt;
  int          m_c, m_n, m_h;
  logic [7:0]  m_prev_res;
  logic [3:0]  hold_pc  = '0;
  logic [7:0]  hold_res = '0;
  logic [4:0]  hold_cnt = '0;

  logic [3:0] e_op, e_addr, e_pc;
  logic [7:0] e_data, e_res;
  logic [4:0] e_cnt;
  logic       e_busy, e_done, e_rv;

  // Expected outputs from the schedule: instruction k is fetched at c=3k+1,
  // issued at 3k+2, captured at 3k+3 and visible at 3k+4 (c=1 is the first
  // cycle after the start edge).
  task automatic calc_exp();
    int end_c, ncap, cap;
    bit running;
    if (!m_active) begin
      e_op = IDLE_OP; e_addr = '0; e_data = '0; e_busy = 0; e_done = 0;
      e_pc = hold_pc; e_res = hold_res; e_rv = 0; e_cnt = hold_cnt;
    end else begin
      end_c   = m_hlt ? 3*m_h + 3 : 3*DEPTH + 1;
      ncap    = m_hlt ? m_h : DEPTH;
      running = (m_c < end_c);
      e_busy  = running;
      e_done  = !running;
      if (running && (m_c % 3 == 2)) {e_op, e_addr, e_data} = run_prog[(m_c-2)/3];
      else begin e_op = IDLE_OP; e_addr = '0; e_data = '0; end
      e_pc  = running ? 4'((m_c-1)/3) : (m_hlt ? 4'(m_h) : 4'(DEPTH-1));
      cap   = (m_c >= 4) ? (m_c-1)/3 : 0;
      if (cap > ncap) cap = ncap;
      e_res = (cap > 0) ? m_res[cap-1] : m_prev_res;
      e_rv  = (m_c >= 4) && (m_c % 3 == 1) && ((m_c-4)/3 < ncap);
      e_cnt = 5'((m_c/3 < m_n) ? m_c/3 : m_n);
    end
  endtask

  task automatic launch(input logic [7:0] prev);
    logic [7:0] scr [DEPTH];
    logic [3:0] op, a;
    logic [7:0] d;
    m_hlt = 0; m_h = 0;
    for (int k = 0; k < DEPTH; k++) begin
      run_prog[k] = m_prog[k];
      scr[k] = ref_mem[k];
      if (!m_hlt && (m_prog[k][15:12] == 4'hF)) begin m_hlt = 1; m_h = k; end
    end
    m_n = m_hlt ? m_h + 1 : DEPTH;
    for (int k = 0; k < m_n; k++) begin
      {op, a, d} = run_prog[k];
      m_res[k] = op_res(op, scr[a], d, 8'h00);
      scr[a]   = op_mem(op, scr[a], d);
    end
    m_prev_res = prev;
    m_c = 1;
    m_active = 1;
  endtask

  // Apply every instruction the CPU actually sampled before leaving the run.
  task automatic commit();
    int exe;
    logic [3:0] op, a;
    logic [7:0] d;
    exe = (m_c + 1) / 3;
    if (exe > m_n) exe = m_n;
    for (int k = 0; k < exe; k++) begin
      {op, a, d} = run_prog[k];
      ref_mem[a] = op_mem(op, ref_mem[a], d);
    end
  endtask

  // Model advance on each edge, using the inputs the DUT samples there.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_active) commit();
      m_active = 0; hold_pc = '0; hold_res = '0; hold_cnt = '0;
    end else if (!m_active) begin
      if (prog_we) m_prog[prog_addr] = prog_wdata;
      if (start && !abort) launch(hold_res);
    end else begin
      calc_exp();
      if (e_done && prog_we) m_prog[prog_addr] = prog_wdata;
      if (abort) begin
        hold_pc = e_pc; hold_res = e_res; hold_cnt = e_cnt;
        commit();
        m_active = 0;
      end else if (e_done && start) begin
        commit();
        launch(e_res);
      end else begin
        m_c++;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      calc_exp();
      check("cpu_opcode", cpu_opcode, e_op);
      check("cpu_address", cpu_address, e_addr);
      check("cpu_data", cpu_data, e_data);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("pc", pc, e_pc);
      check("result", result, e_res);
      check("result_valid", result_valid, e_rv);
      check("instr_count", instr_count, e_cnt);
      if (e_rv) exp_q.push_back(e_res);
      if (result_valid && exp_q.size() > 0) check("rv_value", result, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] w);
    prog_we = 1; prog_addr = 4'(a); prog_wdata = w;
    tick();
    prog_we = 0;
  endtask

  task automatic pulse_start(output int s);
    start = 1; s = cyc;
    tick();
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic wait_neg(input int t);
    @(negedge clk);
    if (cyc > t) check("schedule", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 120 && busy; i++) tick();
    check("drain_bound", busy, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    int sel;
    logic [3:0] op;
    sel = $urandom_range(0, 9);
    if (sel < 3)      op = 4'h0;
    else if (sel < 6) op = 4'h5;
    else if (sel < 8) op = 4'h6;
    else if (sel < 9) op = 4'hF;
    else              op = 4'($urandom_range(0, 15));
    return {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    repeat (3) tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_opcode", cpu_opcode, 4'b0110);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    tick();
    rst = 1;

    // Input then Add, stopped by HLT.
    for (int k = 0; k < DEPTH; k++) write_word(k, {4'h6, 4'(k), 8'h00});
    write_word(0, {4'h5, 4'h3, 8'h2A});
    write_word(1, {4'h0, 4'h3, 8'h05});
    write_word(2, {4'hF, 4'h0, 8'h00});
    pulse_start(s);
    wait_neg(s + 1); check("a_fetch_busy", busy, 1'b1); check("a_fetch_op", cpu_opcode, 4'h6);
    wait_neg(s + 2); check("a_i0", {cpu_opcode, cpu_address, cpu_data}, 16'h532A);
    wait_neg(s + 3); check("a_cap_op", cpu_opcode, 4'h6);
    wait_neg(s + 4); check("a_res0", result, 8'h2A); check("a_rv0", result_valid, 1'b1);
    wait_neg(s + 5); check("a_i1", {cpu_opcode, cpu_address, cpu_data}, 16'h0305);
    wait_neg(s + 7); check("a_res1", result, 8'h2F); check("a_rv1", result_valid, 1'b1);
    wait_neg(s + 8); check("a_hlt_op", cpu_opcode, 4'hF);
    wait_neg(s + 9); check("a_done", done, 1'b1); check("a_cnt", instr_count, 5'd3);
    check("a_pc", pc, 4'd2); check("a_res_hold", result, 8'h2F);
    tick();

    // Full program of Output ops, no HLT.
    for (int k = 0; k < DEPTH; k++) write_word(k, {4'h6, 4'(k), 8'(k)});
    pulse_start(s);
    wait_neg(s + 48); check("f_busy48", busy, 1'b1); check("f_pc48", pc, 4'd15);
    wait_neg(s + 49); check("f_done", done, 1'b1); check("f_pc", pc, 4'd15);
    check("f_cnt", instr_count, 5'd16);
    wait_neg(s + 53); check("f_nowrap_pc", pc, 4'd15); check("f_nowrap_busy", busy, 1'b0);
    tick();

    // Abort during CAPTURE of word 4.
    for (int k = 0; k < DEPTH; k++) write_word(k, {4'h5, 4'(k), 8'(8'h10 + k)});
    pulse_start(s);
    wait_neg(s + 13); check("ab_res3", result, 8'h13);
    wait_neg(s + 14); tick();
    abort = 1; tick(); abort = 0;
    wait_neg(s + 16);
    check("ab_busy", busy, 1'b0); check("ab_done", done, 1'b0);
    check("ab_res", result, 8'h13); check("ab_op", cpu_opcode, 4'h6);
    tick();
    pulse_start(s);
    wait_neg(s + 1); check("ab_restart_pc", pc, 4'd0);
    wait_neg(s + 2); check("ab_restart_i0", {cpu_opcode, cpu_address, cpu_data}, 16'h5010);

    // Write and start while busy are dropped.
    wait_neg(s + 6); tick();
    prog_we = 1; prog_addr = 4'd2; prog_wdata = {4'h5, 4'h2, 8'hFF}; start = 1;
    tick();
    prog_we = 0; start = 0;
    wait_neg(s + 8);  check("bz_pc8", pc, 4'd2);
    wait_neg(s + 10); check("bz_pc10", pc, 4'd3); check("bz_res2", result, 8'h12);
    wait_idle();
    pulse_start(s);
    wait_neg(s + 10); check("bz_rerun_res2", result, 8'h12); check("bz_rerun_rv", result_valid, 1'b1);
    tick();

    // start and prog_we together in IDLE: FETCH sees the new word 0.
    do_abort();
    prog_we = 1; prog_addr = 4'd0; prog_wdata = {4'h5, 4'h1, 8'h77};
    pulse_start(s);
    prog_we = 0;
    wait_neg(s + 2); check("sw_i0", {cpu_opcode, cpu_address, cpu_data}, 16'h5177);
    tick();

    // Reset asserted during an ISSUE cycle.
    do_abort();
    pulse_start(s);
    wait_neg(s + 4); tick();
    rst = 0; tick(); rst = 1;
    wait_neg(s + 6);
    check("mr_op", cpu_opcode, 4'h6); check("mr_busy", busy, 1'b0);
    check("mr_pc", pc, 4'd0); check("mr_cnt", instr_count, 5'd0);
    check("mr_res", result, 8'h00);
    tick();

    // Randomized programs and control.
    for (int it = 0; it < 25; it++) begin
      do_abort();
      for (int k = 0; k < DEPTH; k++) write_word(k, rand_word());
      pulse_start(s);
      for (int j = 0; j < 60; j++) begin
        abort      = ($urandom_range(0, 99) < 2);
        start      = ($urandom_range(0, 99) < 4);
        prog_we    = ($urandom_range(0, 99) < 8);
        prog_addr  = 4'($urandom_range(0, 15));
        prog_wdata = rand_word();
        tick();
      end
      abort = 0; start = 0; prog_we = 0;
    end

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
